time_set_ctrl: RTL and testbench
================================

TIME_SET_CTRL -- requirements
Module: time_set_ctrl

Interface
REQ-001 Parameter DEB_CYCLES, default 50000: consecutive clk cycles a synchronized key must hold a new level before it is accepted.
REQ-002 Parameter REP_DELAY, default 25000000: hold time in clk cycles before the first auto-repeat pulse.
REQ-003 Parameter REP_PERIOD, default 10000000: clk cycles between auto-repeat pulses.
REQ-004 clk  input  1  sole clock; all state is on its rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 mode  input  1  raw mode key, active-high, asynchronous to clk.
REQ-007 increMinUnit, increMinTen, increHourUnit, increHourTen  input  1 each  raw increment keys, active-high, asynchronous.
REQ-008 run_en  output  1  enable to the time counter; high only in RUN.
REQ-009 inc_min_unit, inc_min_ten, inc_hour_unit, inc_hour_ten  output  1 each  single-cycle increment pulses to the time counter.
REQ-010 set_state  output  2  00 RUN, 01 SET_MIN, 10 SET_HOUR; drives digit flashing.

Function
REQ-011 Each of the 5 keys SHALL pass a 2-flop synchronizer, then a debouncer that accepts a new level after DEB_CYCLES consecutive equal samples; any differing sample restarts the count at 0.
REQ-012 A press event SHALL be a single-cycle 0->1 transition of a debounced level; release events SHALL have no effect.
REQ-013 FSM: RUN --mode press--> SET_MIN --mode press--> SET_HOUR --mode press--> RUN; 11 is unreachable and SHALL return to RUN on the next cycle.
REQ-014 run_en SHALL be 1 in RUN and 0 in SET_MIN and SET_HOUR; set_state SHALL equal the state encoding, registered.
REQ-015 In RUN, all increment presses SHALL be discarded.
REQ-016 In SET_MIN only minute presses and in SET_HOUR only hour presses SHALL be accepted; others are discarded.
REQ-017 An accepted press SHALL set a per-key pending flag; one pending flag per cycle SHALL be served, producing exactly one 1-cycle registered pulse on the matching output in the next cycle, then clearing that flag.
REQ-018 Service priority: ten before unit within the active group; at most one inc_* output high in any cycle.
REQ-019 A mode press SHALL take priority over pending increments: same cycle it changes state, clears all pending flags, and suppresses any pulse for that cycle.
REQ-020 A press arriving while its own flag is pending SHALL be merged; no second pulse.
REQ-021 Latency: raw key stable edge to pulse = 2 (sync) + DEB_CYCLES + 1 (event) + 1 (pulse) clk cycles when no other flag is pending.
REQ-022 Debounce and repeat counters SHALL saturate, never wrap.

Reset
REQ-023 While reset is low: state RUN, run_en=1, set_state=00, all inc_* = 0, synchronizers, debounced levels, counters, pending flags = 0.
REQ-024 Reset asserted mid-debounce or with pending flags SHALL discard them; no pulse after release until a fresh qualified press.
REQ-025 Reset deassertion SHALL be synchronized internally (async assert, sync release).

Configuration
REQ-026 Macro TIME_SET_AUTO_REPEAT_EN defined: an accepted increment key held debounced-high SHALL set its pending flag again after REP_DELAY cycles from the press event, then every REP_PERIOD cycles until release or state change.
REQ-027 Macro undefined: exactly one pulse per press; REP_DELAY and REP_PERIOD unused, no repeat counter synthesized.

Verification (DEB_CYCLES=4, REP_DELAY=20, REP_PERIOD=8)
REQ-028 Reset release, no keys for 100 cycles -> run_en=1, set_state=00, no inc_* pulse.
REQ-029 mode pressed 3 times (each held 10 cycles) -> set_state 01, 10, 00 in order; run_en 0,0,1; a 2-cycle glitch on mode causes no change.
REQ-030 In SET_MIN, increMinUnit and increMinTen rise the same cycle -> inc_min_ten pulses 1 cycle, inc_min_unit pulses the next cycle; increHourUnit in SET_MIN -> no pulse.
REQ-031 In SET_HOUR, increHourUnit and mode rise the same cycle -> state to RUN, no inc_hour_unit pulse; reset low mid-debounce of a key -> no pulse after release.
REQ-032 With TIME_SET_AUTO_REPEAT_EN, increMinUnit held 50 cycles after qualification in SET_MIN -> pulses at event+1, +21, +29, +37, +45; without the macro -> single pulse.

Source files
------------

// File: rtl/time_set_ctrl.sv
// rtl/time_set_ctrl.sv - key sync/debounce and RUN/SET_MIN/SET_HOUR control for clock time setting
// Optional auto-repeat of held increment keys: define TIME_SET_AUTO_REPEAT_EN.
module time_set_ctrl #(
  parameter int DEB_CYCLES = 50000,
  parameter int REP_DELAY  = 25000000,
  parameter int REP_PERIOD = 10000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       mode,
  input  logic       increMinUnit,
  input  logic       increMinTen,
  input  logic       increHourUnit,
  input  logic       increHourTen,
  output logic       run_en,
  output logic       inc_min_unit,
  output logic       inc_min_ten,
  output logic       inc_hour_unit,
  output logic       inc_hour_ten,
  output logic [1:0] set_state
);

  localparam int DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);

  typedef enum logic [1:0] {
    S_RUN  = 2'b00,
    S_MIN  = 2'b01,
    S_HOUR = 2'b10,
    S_BAD  = 2'b11
  } state_t;

  logic [1:0] rst_sync;
  logic       rst_n;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rst_sync <= 2'b00;
    end else begin
      rst_sync <= {rst_sync[0], 1'b1};
    end
  end

  assign rst_n = rst_sync[1];

  // Key bit order: 0 mode, 1 min unit, 2 min ten, 3 hour unit, 4 hour ten
  logic [4:0]    raw;
  logic [4:0]    sync1;
  logic [4:0]    sync2;
  logic [4:0]    deb;
  logic [4:0]    deb_d;
  logic [4:0]    press;
  logic [DW-1:0] deb_cnt [5];

  assign raw = {increHourTen, increHourUnit, increMinTen, increMinUnit, mode};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
      deb   <= '0;
      deb_d <= '0;
      press <= '0;
      for (int i = 0; i < 5; i++) begin
        deb_cnt[i] <= '0;
      end
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      deb_d <= deb;
      press <= deb & ~deb_d;
      for (int i = 0; i < 5; i++) begin
        if (sync2[i] == deb[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == DEB_LAST) begin
          deb[i]     <= sync2[i];
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] != '1) begin
          deb_cnt[i] <= deb_cnt[i] + 1'b1;
        end
      end
    end
  end

  // Increment vectors: bit 0 min unit, 1 min ten, 2 hour unit, 3 hour ten
  state_t     state;
  state_t     next_state;
  logic [3:0] pend;
  logic [3:0] inc_q;
  logic [3:0] grp_mask;
  logic [3:0] accepted;
  logic [3:0] rep_fire;
  logic [3:0] want;
  logic [3:0] serve;

  always_comb begin
    next_state = S_RUN;
    grp_mask   = 4'b0000;
    case (state)
      S_RUN: begin
        next_state = S_MIN;
      end
      S_MIN: begin
        next_state = S_HOUR;
        grp_mask   = 4'b0011;
      end
      S_HOUR: begin
        next_state = S_RUN;
        grp_mask   = 4'b1100;
      end
      default: begin
        next_state = S_RUN;
      end
    endcase
    accepted = press[4:1] & grp_mask;
    want     = (pend | accepted | rep_fire) & grp_mask;
    // Tens digit wins over units so a simultaneous pair comes out ten first
    serve = 4'b0000;
    if (want[1]) begin
      serve = 4'b0010;
    end else if (want[0]) begin
      serve = 4'b0001;
    end else if (want[3]) begin
      serve = 4'b1000;
    end else if (want[2]) begin
      serve = 4'b0100;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_RUN;
      run_en    <= 1'b1;
      set_state <= S_RUN;
      pend      <= 4'b0000;
      inc_q     <= 4'b0000;
    end else if (state == S_BAD) begin
      state     <= S_RUN;
      run_en    <= 1'b1;
      set_state <= S_RUN;
      pend      <= 4'b0000;
      inc_q     <= 4'b0000;
    end else if (press[0]) begin
      state     <= next_state;
      run_en    <= (next_state == S_RUN);
      set_state <= next_state;
      pend      <= 4'b0000;
      inc_q     <= 4'b0000;
    end else begin
      pend  <= want & ~serve;
      inc_q <= serve;
    end
  end

`ifdef TIME_SET_AUTO_REPEAT_EN
  localparam int RMAX = (REP_DELAY > REP_PERIOD) ? REP_DELAY : REP_PERIOD;
  localparam int RW   = $clog2(RMAX + 1);

  logic [3:0]    rep_act;
  logic [RW-1:0] rep_cnt [4];

  always_comb begin
    rep_fire = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      rep_fire[i] = rep_act[i] && (rep_cnt[i] == '0) && deb[i+1];
    end
  end

  // Down-counter per key: reaches zero on the cycle a repeat request is due
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rep_act <= 4'b0000;
      for (int i = 0; i < 4; i++) begin
        rep_cnt[i] <= '0;
      end
    end else if (state == S_BAD || press[0]) begin
      rep_act <= 4'b0000;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (accepted[i]) begin
          rep_act[i] <= 1'b1;
          rep_cnt[i] <= RW'(REP_DELAY - 1);
        end else if (rep_act[i]) begin
          if (!deb[i+1]) begin
            rep_act[i] <= 1'b0;
          end else if (rep_cnt[i] == '0) begin
            rep_cnt[i] <= RW'(REP_PERIOD - 1);
          end else begin
            rep_cnt[i] <= rep_cnt[i] - 1'b1;
          end
        end
      end
    end
  end
`else
  assign rep_fire = 4'b0000;
`endif

  assign inc_min_unit  = inc_q[0];
  assign inc_min_ten   = inc_q[1];
  assign inc_hour_unit = inc_q[2];
  assign inc_hour_ten  = inc_q[3];

endmodule

// File: tb/tb_time_set_ctrl.sv
// tb/tb_time_set_ctrl.sv - randomized and directed checks of time_set_ctrl against a behavioural model
// Expectations follow TIME_SET_AUTO_REPEAT_EN when defined.
module tb_time_set_ctrl;

  localparam int DEB = 4;
  localparam int RD  = 20;
  localparam int RP  = 8;

  logic       clk;
  logic       reset;
  logic [4:0] keys;
  logic       run_en;
  logic       inc_min_unit;
  logic       inc_min_ten;
  logic       inc_hour_unit;
  logic       inc_hour_ten;
  logic [1:0] set_state;

  int tests = 0;
  int fails = 0;
  int pulse_total = 0;
  bit chk_en = 0;

  time_set_ctrl #(.DEB_CYCLES(DEB), .REP_DELAY(RD), .REP_PERIOD(RP)) dut (
    .clk           (clk),
    .reset         (reset),
    .mode          (keys[0]),
    .increMinUnit  (keys[1]),
    .increMinTen   (keys[2]),
    .increHourUnit (keys[3]),
    .increHourTen  (keys[4]),
    .run_en        (run_en),
    .inc_min_unit  (inc_min_unit),
    .inc_min_ten   (inc_min_ten),
    .inc_hour_unit (inc_hour_unit),
    .inc_hour_ten  (inc_hour_ten),
    .set_state     (set_state)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  // Model: keys indexed 0 mode, 1 min unit, 2 min ten, 3 hour unit, 4 hour ten
  logic [4:0] hist [16];
  logic [4:0] mdeb;
  logic [4:0] rise1;
  logic [4:0] rise2;
  logic [4:0] mpend;
  logic [3:0] epulse = 4'b0000;
  bit   [4:0] hact;
  int         hstart [5];
  int         mstate = 0;
  int         rcnt = 0;
  int         nedge = 0;

  function automatic bit in_grp(int k, int st);
    return (st == 1 && (k == 1 || k == 2)) || (st == 2 && (k == 3 || k == 4));
  endfunction

  task automatic model_clear();
    for (int j = 0; j < 16; j++) hist[j] = '0;
    mdeb = '0; rise1 = '0; rise2 = '0; mpend = '0; hact = '0;
    mstate = 0; epulse = 4'b0000;
  endtask

  task automatic model_step();
    logic [4:0] newdeb;
    bit all_new;
    nedge++;
    epulse = 4'b0000;
    if (rise2[0]) begin
      mstate = (mstate + 1) % 3;
      mpend = '0;
      hact = '0;
    end else begin
      for (int k = 1; k <= 4; k++) begin
        if (rise2[k] && in_grp(k, mstate)) begin
          mpend[k] = 1'b1; hact[k] = 1'b1; hstart[k] = nedge;
        end
      end
`ifdef TIME_SET_AUTO_REPEAT_EN
      for (int k = 1; k <= 4; k++) begin
        if (hact[k]) begin
          if (!mdeb[k]) hact[k] = 1'b0;
          else if ((nedge - hstart[k]) >= RD && ((nedge - hstart[k] - RD) % RP) == 0) mpend[k] = 1'b1;
        end
      end
`endif
      if (mstate == 1) begin
        if (mpend[2]) begin epulse[1] = 1'b1; mpend[2] = 1'b0; end
        else if (mpend[1]) begin epulse[0] = 1'b1; mpend[1] = 1'b0; end
      end else if (mstate == 2) begin
        if (mpend[4]) begin epulse[3] = 1'b1; mpend[4] = 1'b0; end
        else if (mpend[3]) begin epulse[2] = 1'b1; mpend[3] = 1'b0; end
      end
    end
    for (int j = 15; j > 0; j--) hist[j] = hist[j-1];
    hist[0] = keys;
    // Accept a level once the last DEB synchronized samples all disagree with it
    newdeb = mdeb;
    for (int k = 0; k < 5; k++) begin
      all_new = 1'b1;
      for (int j = 2; j <= DEB + 1; j++) if (hist[j][k] == mdeb[k]) all_new = 1'b0;
      if (all_new) newdeb[k] = ~mdeb[k];
    end
    rise2 = rise1;
    rise1 = newdeb & ~mdeb;
    mdeb = newdeb;
  endtask

  always @(posedge clk) begin
    if (!reset) begin
      model_clear(); rcnt = 0;
    end else if (rcnt < 2) begin
      model_clear(); rcnt++;
    end else begin
      model_step();
    end
  end

  always @(posedge clk) begin
    logic [3:0] got;
    #1;
    if (chk_en) begin
      got = {inc_hour_ten, inc_hour_unit, inc_min_ten, inc_min_unit};
      if (got != 4'b0000) pulse_total++;
      tests++;
      if (got !== epulse || set_state !== 2'(mstate) || run_en !== (mstate == 0)) begin
        fails++;
        $display("FAIL model_cmp t=%0t: inc=%b want %b, set_state=%0d want %0d, run_en=%b want %b",
                 $time, got, epulse, set_state, mstate, run_en, (mstate == 0));
      end
      tests++;
      if ($countones(got) > 1) begin
        fails++;
        $display("FAIL one_hot t=%0t: inc=%b has more than one bit set", $time, got);
      end
    end
  end

  task automatic tick(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(string name, int got, int exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic mode_press(int exp_state);
    int seen = -1;
    keys[0] = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (seen < 0 && set_state == 2'(exp_state)) seen = i;
      if (i == 10) keys[0] = 1'b0;
    end
    check("mode_latency", seen, DEB + 4);
    check("mode_state", set_state, exp_state);
    check("mode_run_en", run_en, (exp_state == 0) ? 1 : 0);
  endtask

  initial begin
    int p0;
    int t_ten;
    int t_unit;
    int q[$];
    int exp_q[$];
    int rem[5];
    int rst_hold;

    keys = '0;
    reset = 1'b0;
    tick(4);
    chk_en = 1;
    reset = 1'b1;
    tick(100);
    check("idle_run_en", run_en, 1);
    check("idle_set_state", set_state, 0);
    check("idle_pulses", pulse_total, 0);

    mode_press(1);
    keys[0] = 1'b1; tick(2); keys[0] = 1'b0; tick(15);
    check("glitch_state", set_state, 1);
    mode_press(2);
    mode_press(0);
    mode_press(1);

    keys[1] = 1'b1; keys[2] = 1'b1;
    t_ten = -1; t_unit = -1; p0 = pulse_total;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (inc_min_ten && t_ten < 0) t_ten = i;
      if (inc_min_unit && t_unit < 0) t_unit = i;
      if (i == 12) begin keys[1] = 1'b0; keys[2] = 1'b0; end
    end
    check("min_ten_latency", t_ten, DEB + 4);
    check("min_unit_latency", t_unit, DEB + 5);
    check("min_pair_pulses", pulse_total - p0, 2);

    p0 = pulse_total;
    keys[3] = 1'b1; tick(10); keys[3] = 1'b0; tick(15);
    check("hour_in_set_min", pulse_total - p0, 0);

    mode_press(2);
    p0 = pulse_total;
    keys[3] = 1'b1; keys[0] = 1'b1; tick(10); keys[3] = 1'b0; keys[0] = 1'b0; tick(15);
    check("mode_beats_hour_state", set_state, 0);
    check("mode_beats_hour_pulse", pulse_total - p0, 0);

    mode_press(1);
    keys[1] = 1'b1; tick(3);
    reset = 1'b0; tick(3);
    keys[1] = 1'b0; tick(2);
    reset = 1'b1;
    p0 = pulse_total;
    tick(30);
    check("reset_mid_deb_pulse", pulse_total - p0, 0);
    check("reset_state", set_state, 0);
    check("reset_run_en", run_en, 1);

    mode_press(1);
    keys[1] = 1'b1;
    for (int i = 1; i <= 80; i++) begin
      @(negedge clk);
      if (inc_min_unit) q.push_back(i);
      if (i == 50) keys[1] = 1'b0;
    end
`ifdef TIME_SET_AUTO_REPEAT_EN
    exp_q = '{8, 28, 36, 44, 52};
`else
    exp_q = '{8};
`endif
    check("repeat_count", q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < q.size(); i++) check("repeat_time", q[i], exp_q[i]);
    mode_press(2);
    mode_press(0);

    for (int k = 0; k < 5; k++) rem[k] = $urandom_range(1, 30);
    rst_hold = 0;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      for (int k = 0; k < 5; k++) begin
        if (rem[k] == 0) begin
          keys[k] = ~keys[k];
          if (keys[k]) rem[k] = $urandom_range(1, 14);
          else rem[k] = (k == 0) ? $urandom_range(20, 150) : $urandom_range(1, 30);
        end else begin
          rem[k]--;
        end
      end
      if (rst_hold > 0) begin
        rst_hold--;
        if (rst_hold == 0) reset = 1'b1;
      end else if ($urandom_range(0, 999) == 0) begin
        reset = 1'b0;
        rst_hold = 3;
      end
    end
    reset = 1'b1;
    keys = '0;
    tick(20);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
